// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit sampling, optional
// parity, 1/2 stop bits, break hold-off and a valid/ready output register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 uart_rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_VOTE = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_TWO  = (STOP_BITS == 2);
    localparam logic          ODD    = (PARITY_ODD != 0);
    localparam logic          PAR    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 mism_q, mism_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    logic rx_s;
    logic vote;
    logic tick_end;
    logic is_vote;
    logic is_end;
    logic good;

    assign rx_s     = sync2_q;
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign tick_end = (cnt_q == C_LAST);
    assign is_vote  = baud_tick && (cnt_q == C_VOTE);
    assign is_end   = baud_tick && tick_end;

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign busy       = (state_q != IDLE);

    // Next-state: bit timing, frame decoding, delivery and error pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        mism_d  = mism_q;
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        good    = 1'b0;

        if (state_q != IDLE && state_q != BREAK && baud_tick) begin
            if (cnt_q == C_S0) smp_d[0] = rx_s;
            if (cnt_q == C_S1) smp_d[1] = rx_s;
            cnt_d = tick_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                mism_d = 1'b0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (is_vote && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (is_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (is_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (is_end) begin
                    if (bit_q == B_LAST) begin
                        state_d = PAR ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (is_vote) mism_d = (vote != ((^shift_q) ^ ODD));
                if (is_end) state_d = STOP;
            end
            STOP: begin
                if (is_vote) begin
                    if (!vote) begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                        cnt_d   = '0;
                    end else if (stop_q == S_TWO) begin
                        if (mism_q) pe_d = 1'b1;
                        else        good = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (is_end) begin
                    stop_d = 1'b1;
                end
            end
            BREAK: begin
                if (baud_tick) begin
                    if (!rx_s) begin
                        cnt_d = '0;
                    end else if (tick_end) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (good) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; line synchronizer idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            smp_q   <= '0;
            shift_q <= '0;
            mism_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            mism_q  <= mism_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance driven
// from a shared tick; good words are checked through a scoreboard queue.
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic reset;
    logic baud_tick;
    logic rx_a, rx_p;
    logic rdy_a, rdy_p;
    logic [7:0] data_a, data_p;
    logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic valid_p, perr_p, ferr_p, ovr_p, busy_p;

    int total = 0;
    int bad = 0;
    int np_a = 0, nf_a = 0, no_a = 0;
    int np_p = 0, nf_p = 0, no_p = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] d;
        logic       stopv;
        logic       exp_ok;
    } vec_t;

    vec_t tbl[6];

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) u_a (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .uart_rx(rx_a), .rx_ready(rdy_a), .rx_data(data_a),
        .rx_valid(valid_a), .parity_err(perr_a), .frame_err(ferr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) u_p (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .uart_rx(rx_p), .rx_ready(rdy_p), .rx_data(data_p),
        .rx_valid(valid_p), .parity_err(perr_p), .frame_err(ferr_p),
        .overrun(ovr_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // One tick every four clocks, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Count single-cycle error pulses away from the active edge.
    always @(negedge clk) begin
        if (perr_a) np_a++;
        if (ferr_a) nf_a++;
        if (ovr_a)  no_a++;
        if (perr_p) np_p++;
        if (ferr_p) nf_p++;
        if (ovr_p)  no_p++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic set_line(input bit ch, input logic v);
        if (ch) rx_p = v;
        else    rx_a = v;
    endtask

    task automatic send(input bit ch, input logic [7:0] d, input bit use_par,
                        input logic pbit, input logic stopv,
                        input int stop_ticks, input bit pulse);
        wait_ticks(1);
        set_line(ch, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, d[i]);
            wait_ticks(16);
        end
        if (use_par) begin
            set_line(ch, pbit);
            wait_ticks(16);
        end
        set_line(ch, stopv);
        if (pulse) begin
            wait_ticks(9);
            repeat (3) @(negedge clk);
            rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0;
            wait_ticks(stop_ticks - 10);
        end else begin
            wait_ticks(stop_ticks);
        end
        set_line(ch, 1'b1);
    endtask

    task automatic check_word(input bit ch, input string nm);
        logic [7:0] exp;
        int n;
        n = 0;
        while (!(ch ? valid_p : valid_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, ch ? valid_p : valid_a, 1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got empty queue want entry", nm);
        end else begin
            exp = sb.pop_front();
            chk({nm, "_data"}, ch ? data_p : data_a, exp);
        end
    endtask

    task automatic consume(input bit ch, input string nm);
        if (ch) rdy_p = 1'b1;
        else    rdy_a = 1'b1;
        @(negedge clk);
        rdy_p = 1'b0;
        rdy_a = 1'b0;
        chk({nm, "_drop"}, ch ? valid_p : valid_a, 0);
    endtask

    initial begin
        int e0, f0, o0;

        tbl[0] = '{8'hA5, 1'b1, 1'b1};
        tbl[1] = '{8'h00, 1'b1, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b0};
        tbl[4] = '{8'h55, 1'b1, 1'b1};
        tbl[5] = '{8'h81, 1'b1, 1'b1};

        reset = 1'b1;
        rx_a  = 1'b1;
        rx_p  = 1'b1;
        rdy_a = 1'b0;
        rdy_p = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", {perr_a, ferr_a, ovr_a}, 0);
        reset = 1'b0;
        wait_ticks(4);

        for (int i = 0; i < 6; i++) begin
            e0 = np_a;
            f0 = nf_a;
            o0 = no_a;
            if (tbl[i].exp_ok) sb.push_back(tbl[i].d);
            send(0, tbl[i].d, 0, 1'b0, tbl[i].stopv,
                 tbl[i].stopv ? 16 : 32, 0);
            if (tbl[i].exp_ok) begin
                check_word(0, "vec");
                chk("vec_ferr", nf_a - f0, 0);
                chk("vec_perr", np_a - e0, 0);
                chk("vec_ovr", no_a - o0, 0);
                consume(0, "vec");
            end else begin
                chk("vec_ferr", nf_a - f0, 1);
                chk("vec_perr", np_a - e0, 0);
                chk("vec_nodeliver", valid_a, 0);
                wait_ticks(12);
                chk("brk_hold", busy_a, 1);
                wait_ticks(6);
                chk("brk_exit", busy_a, 0);
            end
        end

        e0 = np_a;
        f0 = nf_a;
        wait_ticks(1);
        rx_a = 1'b0;
        wait_ticks(3);
        chk("glitch_busy", busy_a, 1);
        wait_ticks(1);
        rx_a = 1'b1;
        wait_ticks(12);
        chk("glitch_idle", busy_a, 0);
        chk("glitch_valid", valid_a, 0);
        chk("glitch_err", (np_a - e0) + (nf_a - f0), 0);

        sb.push_back(8'h11);
        send(0, 8'h11, 0, 1'b0, 1'b1, 16, 0);
        check_word(0, "ovr1");
        o0 = no_a;
        send(0, 8'h22, 0, 1'b0, 1'b1, 16, 0);
        chk("ovr_pulse", no_a - o0, 1);
        chk("ovr_keep", data_a, 8'h11);
        chk("ovr_valid", valid_a, 1);
        consume(0, "ovr");

        sb.push_back(8'h11);
        send(0, 8'h11, 0, 1'b0, 1'b1, 16, 0);
        check_word(0, "same1");
        o0 = no_a;
        sb.push_back(8'h22);
        send(0, 8'h22, 0, 1'b0, 1'b1, 16, 1);
        check_word(0, "same2");
        chk("same_noovr", no_a - o0, 0);
        consume(0, "same");

        e0 = np_p;
        f0 = nf_p;
        send(1, 8'h07, 1, 1'b0, 1'b1, 16, 0);
        chk("par_pulse", np_p - e0, 1);
        chk("par_ferr", nf_p - f0, 0);
        chk("par_valid", valid_p, 0);
        sb.push_back(8'h07);
        send(1, 8'h07, 1, 1'b1, 1'b1, 16, 0);
        check_word(1, "par_ok");
        chk("par_ok_err", np_p - e0, 1);
        consume(1, "par");
        e0 = np_p;
        f0 = nf_p;
        send(1, 8'h5A, 1, 1'b1, 1'b0, 32, 0);
        chk("prec_ferr", nf_p - f0, 1);
        chk("prec_perr", np_p - e0, 0);
        chk("prec_valid", valid_p, 0);
        wait_ticks(20);
        chk("prec_idle", busy_p, 0);

        sb.push_back(8'h33);
        send(0, 8'h33, 0, 1'b0, 1'b1, 16, 0);
        check_word(0, "pre_rst");
        e0 = np_a;
        f0 = nf_a;
        o0 = no_a;
        wait_ticks(1);
        rx_a = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_a = (i > 3);
            wait_ticks(16);
        end
        chk("mid_busy", busy_a, 1);
        reset = 1'b1;
        rx_a  = 1'b1;
        @(negedge clk);
        chk("mrst_valid", valid_a, 0);
        chk("mrst_data", data_a, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_err", {perr_a, ferr_a, ovr_a}, 0);
        reset = 1'b0;
        wait_ticks(20);
        sb.push_back(8'h0F);
        send(0, 8'h0F, 0, 1'b0, 1'b1, 16, 0);
        check_word(0, "post_rst");
        chk("post_rst_err", (np_a - e0) + (nf_a - f0) + (no_a - o0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, 16: baud_tick pulses per bit period; even; legal range 8..64.
REQ-003 Parameter PARITY_EN, 0: 1 means one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, 0: 1 means odd parity, 0 means even parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, 1: number of stop bits checked; 1 or 2.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-008 baud_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-009 uart_rx  in  1  asynchronous serial line; idle high.
REQ-010 rx_ready  in  1  consumer accepts rx_data when high together with rx_valid.
REQ-011 rx_data  out  DATA_BITS  last delivered word, LSB received first.
REQ-012 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-013 parity_err  out  1  one-clk pulse on parity mismatch.
REQ-014 frame_err  out  1  one-clk pulse when a stop bit samples 0.
REQ-015 overrun  out  1  one-clk pulse when a good frame is dropped because rx_valid is still held.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 uart_rx SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1; all logic below SHALL use the synchronized value.
REQ-018 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide, SHALL advance only on baud_tick, and SHALL wrap from OVERSAMPLE-1 to 0.
REQ-019 Each bit value SHALL be the majority of 3 samples taken on the ticks at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-020 The block SHALL use the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-021 IDLE -> START SHALL occur when the synchronized line is 0; the tick counter SHALL clear on entry to START.
REQ-022 In START, a voted 1 SHALL mark a false start: the FSM SHALL return to IDLE, deliver nothing and raise no error.
REQ-023 In START, a voted 0 SHALL move the FSM to DATA at the end of the bit period.
REQ-024 DATA SHALL shift in DATA_BITS bits, LSB first, using a bit counter; after the last bit the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-025 PARITY SHALL compare the voted bit with the XOR of the data bits, inverted when PARITY_ODD=1, and SHALL record any mismatch.
REQ-026 STOP SHALL check STOP_BITS bits; the frame SHALL be decided at the vote point of the last stop bit, without waiting for the end of the bit.
REQ-027 Good frame (all stop bits 1, no parity mismatch):
- rx_data SHALL load and rx_valid SHALL be 1 on the next clk;
- the FSM SHALL return to IDLE.
REQ-028 Parity error: parity_err SHALL pulse, nothing SHALL be delivered, and the FSM SHALL go to IDLE.
REQ-029 Any stop bit voting 0 SHALL cause:
- a frame_err pulse (this takes precedence over parity_err, which SHALL NOT pulse);
- no delivery;
- entry to BREAK.
REQ-030 BREAK SHALL exit to IDLE only after the synchronized line has been 1 for OVERSAMPLE consecutive ticks.
REQ-031 rx_valid SHALL stay high until a clk with rx_valid & rx_ready, then fall on the next clk unless a new word loads in that same clk.
REQ-032 A good frame arriving while rx_valid=1 and rx_ready=0 SHALL pulse overrun; the held rx_data SHALL be kept and the new word dropped.
REQ-033 A good frame arriving in the same clk as a consume SHALL load the new word with rx_valid staying 1 and SHALL NOT pulse overrun.
REQ-034 baud_tick SHALL be ignored in IDLE; state SHALL advance only on baud_tick outside IDLE.

Reset
REQ-035 On reset the block SHALL enter IDLE with: all counters 0; rx_data 0; rx_valid, parity_err, frame_err, overrun and busy 0; synchronizer flops 1.
REQ-036 Reset SHALL take priority over every other event, including mid-frame; the partial frame SHALL be discarded with no error pulse.

Verification
REQ-037 8N1, OVERSAMPLE=16, send 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, no error pulse; rx_ready=1 for one clk -> rx_valid=0 on the next clk.
REQ-038 Low glitch of 4 ticks on an idle line -> false start, busy returns to 0, rx_valid stays 0, no error pulse.
REQ-039 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulses once, rx_valid stays 0.
REQ-040 Send 0x3C with stop bit 0, line held low for 2 bit periods -> frame_err pulses once, FSM stays in BREAK until 16 high ticks, then 0x55 is received correctly.
REQ-041 Send 0x11, then 0x22 with rx_ready=0 -> overrun pulses once, rx_data=0x11; repeat with rx_ready=1 at the second frame's decision clk -> rx_data=0x22, no overrun.
REQ-042 Reset asserted mid-DATA of 0xF0 -> all outputs 0 next clk; a following 0x0F is received correctly.
